// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the serial slice adder.
package adder_seq_pkg;

  // Default width of the adder slice processed each cycle.
  localparam int unsigned SliceWDefault = 8;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_e;

endpackage

// File: rtl/adder_carry_slice.sv
// Combinational W-bit adder slice with carry-in and carry-out.
module adder_carry_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] ext;

  // Extend by one bit so the slice carry falls out as the top bit.
  always_comb begin
    ext  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum  = ext[W-1:0];
    cout = ext[W];
  end

endmodule

// File: rtl/adder_seq_para.sv
// Serial N-bit adder: K = N/W slice additions, least-significant slice first,
// carry kept in a 1-bit register between slices.
// Optional feature: define ADDER_SEQ_OVF_EN to add a registered signed-overflow
// output ovf.
module adder_seq_para
  import adder_seq_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = SliceWDefault
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned K    = N / W;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] LastSlice = CntW'(K - 1);

  if ((N % W) != 0 || N < W) begin : g_param_check
    $error("adder_seq_para: N must be a non-zero multiple of W");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
`ifdef ADDER_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  int unsigned     base;
  logic [W-1:0]    sl_a, sl_b, sl_sum;
  logic            sl_cout;

  // Select the operand slice addressed by the slice counter.
  always_comb begin
    base = int'(cnt_q) * W;
    sl_a = a_q[base +: W];
    sl_b = b_q[base +: W];
  end

  adder_carry_slice #(
    .W(W)
  ) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .sum (sl_sum),
    .cout(sl_cout)
  );

  // Next-state: capture on start, one slice per OP cycle, publish on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = OP;
        end
      end
      OP: begin
        acc_d[base +: W] = sl_sum;
        carry_d          = sl_cout;
        if (cnt_q == LastSlice) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = sl_cout;
`ifdef ADDER_SEQ_OVF_EN
          // a^b^sum at the MSB recovers the carry into bit N-1.
          ovf_d   = a_q[N-1] ^ b_q[N-1] ^ sl_sum[W-1] ^ sl_cout;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    ready     = (state_q == IDLE);
    done_tick = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_adder_seq_para.sv
// Bench for adder_seq_para at N=16, W=4 (K=4). Driver pushes expected results
// into a queue; a monitor pops and compares on every done_tick.
module tb_adder_seq_para;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         ready;
  logic         done_tick;
  logic [N-1:0] sum;
  logic         cout;
`ifdef ADDER_SEQ_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   nops  = 0;
  int   ndone = 0;

  adder_seq_para #(
    .N(N),
    .W(W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .done_tick(done_tick),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Wait for ready, then drive one start pulse; wt counts negedges spent.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                       input logic [N-1:0] es, input logic ec, input logic ev,
                       input bit push, output int wt);
    exp_t e;
    @(negedge clk);
    wt = 1;
    while (!ready && wt < 30) begin
      @(negedge clk);
      wt++;
    end
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.v = ev;
      exp_q.push_back(e);
      nops++;
    end
  endtask

  // Drop start and count negedges until done_tick; lo counts cycles with ready low.
  task automatic wait_done(output int n, output int lo);
    bit seen;
    seen = 1'b0;
    n    = 0;
    lo   = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (!ready) lo++;
      if (done_tick) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  // Monitor: every done_tick must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_tick) begin
        ndone++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
`ifdef ADDER_SEQ_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.v));
`endif
        end
      end
    end
  end

  initial begin
    int          wt, n, lo;
    logic [N-1:0] ra, rb;
    logic         rc;
    logic [N:0]   full;
    logic         rv;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    reset_n = 1'b1;

    // Basic add with latency and ready-low window.
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    chk("latency", 32'(n), 32'd5);
    chk("ready_low", 32'(lo), 32'd5);

    // Carry and overflow corner cases.
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, wt);
    wait_done(n, lo);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, wt);
    wait_done(n, lo);

    // Back-to-back: second start in the cycle after done_tick.
    issue(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    issue(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    chk("b2b_gap", 32'(wt + n), 32'd6);

    // Operands zeroed and start held high through OP and DONE.
    issue(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b1, wt);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      start = 1'b1;
      chk("hold_ready_low", 32'(ready), 32'd0);
    end
    @(negedge clk);
    chk("hold_done", 32'(done_tick), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("hold_idle", 32'(ready), 32'd1);
    @(negedge clk);
    chk("hold_no_restart", 32'(ready), 32'd1);

    // Reset during the second OP cycle aborts the operation.
    issue(16'h1111, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wt);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done_tick), 32'd0);
    #1 reset_n = 1'b1;
    issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, wt);
    wait_done(n, lo);
    chk("post_reset_latency", 32'(n), 32'd5);

    // Random operations against an N+1-bit reference.
    for (int i = 0; i < 1000; i++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      rv   = (ra[N-1] == rb[N-1]) && (full[N-1] != ra[N-1]);
      issue(ra, rb, rc, full[N-1:0], full[N], rv, 1'b1, wt);
      wait_done(n, lo);
      if (i < 3) chk("rand_latency", 32'(n), 32'd5);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(ndone), 32'(nops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_seq_para.md
ADDER_SEQ_PARA -- requirements
Module: adder_seq_para

Interface
REQ-001 Parameter N, default 32, operand/result width in bits.
REQ-002 Parameter W, default 8, width of the adder slice used each cycle; N SHALL be an integer multiple of W and N >= W (elaboration-time assertion).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled only when ready=1.
REQ-006 a, b  input  N  operands, unsigned (two's complement for overflow feature).
REQ-007 cin  input  1  carry-in, added at bit 0.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done_tick  output  1  one-cycle pulse marking a new valid result.
REQ-010 sum  output  N  registered result.
REQ-011 cout  output  1  registered carry-out of bit N-1.

Function
REQ-012 K = N/W; the addition SHALL run as K serial W-bit slice additions, least-significant slice first, carry propagated through a 1-bit carry register.
REQ-013 FSM states: IDLE, OP, DONE. IDLE->OP on start=1; OP->OP while the slice counter < K-1; OP->DONE after slice K-1; DONE->IDLE unconditionally.
REQ-014 On the start edge, a, b and cin SHALL be captured into internal registers; operand changes after that edge SHALL NOT affect the result.
REQ-015 ready=1 only in IDLE; start is ignored in OP and DONE.
REQ-016 done_tick=1 only in DONE, exactly K+1 cycles after the cycle in which start was sampled.
REQ-017 sum and cout SHALL update only on entry to DONE, then hold until the next entry to DONE; intermediate slice results SHALL NOT appear on sum.
REQ-018 Result SHALL equal the low N bits and bit N of a + b + cin, evaluated at N+1 bits with no truncation of the carry.
REQ-019 Back-to-back: start asserted in the cycle after done_tick (IDLE) SHALL be accepted; throughput is one result per K+2 cycles.
REQ-020 N=W (K=1) SHALL work: a single OP cycle.

Reset
REQ-021 With reset_n low: state=IDLE, ready=1, done_tick=0, sum=0, cout=0, slice counter, carry and operand registers=0, taking effect immediately (asynchronous).
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done_tick; the next start after release SHALL behave normally.

Configuration
REQ-023 Macro ADDER_SEQ_OVF_EN defined: an extra output ovf (1 bit) SHALL be present, registered with sum, equal to carry into bit N-1 XOR carry out of bit N-1 (signed overflow); reset value 0.
REQ-024 Macro undefined: no ovf port and no associated logic; all other behaviour identical.

Structure
REQ-025 Package adder_seq_pkg SHALL hold the FSM state enum typedef (IDLE, OP, DONE) and the default W constant; N-dependent widths stay local parameters.
REQ-026 One combinational sub-module adder_carry_slice (parameter W; inputs a, b [W], cin; outputs sum [W], cout) SHALL implement the per-cycle slice addition via an extended W+1-bit sum.

Verification (N=16, W=4, K=4)
REQ-027 a=0x1234, b=0x4321, cin=0, start pulse -> ready low 5 cycles, done_tick on 5th cycle, sum=0x5555, cout=0.
REQ-028 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-029 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 (macro defined); ovf port absent when undefined.
REQ-030 Start accepted, then operands changed to 0 and start held high during OP -> result still from the original operands, exactly one done_tick, next operation begins only from IDLE.
REQ-031 reset_n pulsed low during the 2nd OP cycle -> sum=0, cout=0, ready=1 immediately, no done_tick; the next start with a=0x0F0F, b=0x00F1 -> sum=0x1000, cout=0.
REQ-032 Two back-to-back operations (start in the cycle after done_tick) -> two done_ticks 6 cycles apart, each with the correct result; random N+1-bit reference model compared over 1000 operations.
